lcd_ctrl: RTL and testbench
===========================

Name: lcd_ctrl

Overview:
- Downstream consumer of the LSU LCD output register (o_io_lcd).
- Turns software-written LCD words into correctly timed HD44780 write cycles on the DE2 character-LCD pins: RS/DATA setup, EN pulse, hold, then command execution wait.
- Removes per-pin bit-banging from firmware. Reports busy status that can be looped back to a readable I/O address.

Parameters:
- T_AS_CYC, 2: cycles RS/DATA are stable before EN rises (min 1).
- T_PW_CYC, 12: cycles EN is held high (min 1).
- T_H_CYC, 2: cycles RS/DATA are held after EN falls (min 1).
- T_EXEC_CYC, 2000: wait after a normal command or data write (min 1).
- T_EXEC_LONG_CYC, 82000: wait after clear/home commands (min 1).
- T_PWRON_CYC, 750000: power-on wait. Used only with LCD_CTRL_INIT_EN.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_lcd_reg  in  32  LCD register from LSU. [31] ON, [16] GO, [9] RS, [7:0] DATA. Other bits ignored.
- o_lcd_on  out  1  LCD power/backlight enable.
- o_lcd_en  out  1  HD44780 EN strobe.
- o_lcd_rs  out  1  HD44780 register select.
- o_lcd_rw  out  1  HD44780 R/W, always 0 (write only).
- o_lcd_data  out  8  HD44780 data bus.
- o_busy  out  1  transfer in progress or request pending.
- o_overflow  out  1  sticky: a GO edge was dropped.

Behaviour:
- Reset (async assert, sync release): o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0, o_lcd_on=0, o_busy=0, o_overflow=0, FSM=IDLE, pending empty, GO edge register=0.
- o_lcd_on is i_lcd_reg[31], registered (1-cycle latency). It is independent of the FSM.
- Request detect:
  - Register i_lcd_reg[16] as go_q.
  - Request when i_lcd_reg[16]=1 and go_q=0. A level held high issues only one request.
  - On the request cycle, capture {RS, DATA}.
- One-deep pending buffer:
  - FSM in IDLE, no pending: request starts SETUP next cycle.
  - FSM not IDLE, pending empty: request stored in pending.
  - Pending full: request dropped, o_overflow<=1 (sticky until reset).
- FSM, with a single down-counter cnt sized for the largest parameter:
  - IDLE: if pending is valid, pop it; else take a new request. Load RS/DATA outputs, cnt=T_AS_CYC-1, go SETUP.
  - SETUP: EN=0. When cnt==0, EN<=1, cnt=T_PW_CYC-1, go PULSE.
  - PULSE: EN=1. When cnt==0, EN<=0, cnt=T_H_CYC-1, go HOLD.
  - HOLD: EN=0, RS/DATA unchanged. When cnt==0, load the exec wait, go WAIT.
    - Exec wait = T_EXEC_LONG_CYC-1 if RS=0 and DATA in {0x01,0x02,0x03}.
    - Otherwise exec wait = T_EXEC_CYC-1.
  - WAIT: when cnt==0, go IDLE. If pending is valid, IDLE launches it on the next cycle (one IDLE cycle between transfers).
- Durations, counted from the cycle after IDLE launches:
  - EN high for exactly T_PW_CYC cycles.
  - EN rises T_AS_CYC cycles after RS/DATA change.
  - RS/DATA stay stable ≥ T_H_CYC cycles after EN falls.
- o_busy = (FSM != IDLE) | pending valid. It goes high the cycle after an accepted request.
- Simultaneous events:
  - Request in the same cycle IDLE pops pending: the new request goes to pending. It is not dropped.
  - Request in the WAIT cycle where cnt==0: stored in pending.
- RS/DATA outputs hold their last values in IDLE.
- Reset mid-transfer: EN drops immediately (async). Pending and overflow clear. No partial strobe completes.

Optional Feature:
- Macro LCD_CTRL_INIT_EN.
- Defined:
  - After reset, enter INIT instead of IDLE. Wait T_PWRON_CYC.
  - Then issue internal writes 0x38, 0x0C, 0x01, 0x06 (RS=0) with full SETUP/PULSE/HOLD/WAIT timing; 0x01 uses the long wait.
  - o_busy=1 throughout INIT.
  - GO requests during INIT follow the normal pending/overflow rules and are served after INIT.
- Undefined: INIT state, ROM and T_PWRON_CYC logic are absent. The FSM enters IDLE out of reset.

Test Plan (sim params: T_AS=2, T_PW=3, T_H=2, T_EXEC=5, T_EXEC_LONG=20, T_PWRON=10):
1. Reset, then i_lcd_reg=0x0001_0241 (GO, RS=1, DATA=0x41) -> EN high exactly 3 cycles, starting 2 cycles after rs=1/data=0x41. o_busy high for 2+3+2+5=12 cycles. rw always 0.
2. Write 0x0001_0001 (clear) -> WAIT lasts 20 cycles. Then 0x0001_0080 (set DDRAM) -> WAIT lasts 5 cycles.
3. GO held high 50 cycles, DATA=0x55 -> exactly one EN pulse.
4. Three GO edges (0x31, 0x32, 0x33) during one transfer -> 0x31 completes, 0x32 is sent next, 0x33 dropped, o_overflow=1 until reset.
5. Assert i_rst_n=0 while EN=1 -> EN, busy, overflow all 0 immediately. After release, a new GO works normally.
6. With LCD_CTRL_INIT_EN -> busy from reset. After 10 cycles, EN pulses carry 0x38, 0x0C, 0x01, 0x06 in order. A GO issued during INIT is served afterwards. Without the macro, busy=0 right after reset.

Source files
------------

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: turns LSU LCD register writes into timed EN strobes.
// Optional power-on init sequence is built when LCD_CTRL_INIT_EN is defined.
module lcd_ctrl #(
    parameter int T_AS_CYC        = 2,
    parameter int T_PW_CYC        = 12,
    parameter int T_H_CYC         = 2,
    parameter int T_EXEC_CYC      = 2000,
    parameter int T_EXEC_LONG_CYC = 82000,
    parameter int T_PWRON_CYC     = 750000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_lcd_reg,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy,
    output logic        o_overflow
);
    localparam int MAX_A   = (T_AS_CYC > T_PW_CYC) ? T_AS_CYC : T_PW_CYC;
    localparam int MAX_B   = (MAX_A > T_H_CYC) ? MAX_A : T_H_CYC;
    localparam int MAX_C   = (MAX_B > T_EXEC_CYC) ? MAX_B : T_EXEC_CYC;
    localparam int MAX_D   = (MAX_C > T_EXEC_LONG_CYC) ? MAX_C : T_EXEC_LONG_CYC;
    localparam int MAX_ALL = (MAX_D > T_PWRON_CYC) ? MAX_D : T_PWRON_CYC;
    localparam int CNT_W   = $clog2(MAX_ALL + 1);

    localparam logic [CNT_W-1:0] AS_LD    = CNT_W'(T_AS_CYC - 1);
    localparam logic [CNT_W-1:0] PW_LD    = CNT_W'(T_PW_CYC - 1);
    localparam logic [CNT_W-1:0] H_LD     = CNT_W'(T_H_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(T_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(T_EXEC_LONG_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT, INIT} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             go_q;
    logic             pend_valid;
    logic [8:0]       pend_word;
    logic             req;
    logic [8:0]       req_word;
    logic             init_work;
    logic [8:0]       init_word;
    logic             launch;
    logic [8:0]       launch_word;
    logic             take_req;
    logic             pop_pend;
    logic             exec_long;
    logic             unused_bits;

    assign req         = i_lcd_reg[16] & ~go_q;
    assign req_word    = {i_lcd_reg[9], i_lcd_reg[7:0]};
    assign unused_bits = ^{i_lcd_reg[30:17], i_lcd_reg[15:10], i_lcd_reg[8]};

`ifdef LCD_CTRL_INIT_EN
    logic [2:0] init_idx;
    localparam logic [CNT_W-1:0] PWRON_LD = CNT_W'(T_PWRON_CYC - 1);

    assign init_work = (init_idx != 3'd4);
    always_comb begin
        init_word = 9'h038;
        case (init_idx[1:0])
            2'd0: init_word = 9'h038;
            2'd1: init_word = 9'h00C;
            2'd2: init_word = 9'h001;
            2'd3: init_word = 9'h006;
            default: init_word = 9'h038;
        endcase
    end
`else
    assign init_work = 1'b0;
    assign init_word = 9'h000;
`endif

    // Launch priority in IDLE: init ROM, then the pending slot, then a fresh request.
    always_comb begin
        launch      = 1'b0;
        launch_word = req_word;
        take_req    = 1'b0;
        pop_pend    = 1'b0;
        if (state == IDLE) begin
            launch = init_work | pend_valid | req;
            if (init_work) begin
                launch_word = init_word;
            end else if (pend_valid) begin
                pop_pend    = 1'b1;
                launch_word = pend_word;
            end else begin
                take_req = req;
            end
        end
    end

    assign exec_long = ~o_lcd_rs &
                       ((o_lcd_data == 8'h01) | (o_lcd_data == 8'h02) | (o_lcd_data == 8'h03));
    assign o_lcd_rw  = 1'b0;
    assign o_busy    = (state != IDLE) | pend_valid | init_work;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
`ifdef LCD_CTRL_INIT_EN
            state    <= INIT;
            cnt      <= PWRON_LD;
            init_idx <= 3'd0;
`else
            state    <= IDLE;
            cnt      <= '0;
`endif
            go_q       <= 1'b0;
            pend_valid <= 1'b0;
            pend_word  <= 9'h000;
            o_lcd_on   <= 1'b0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
            o_overflow <= 1'b0;
        end else begin
            go_q     <= i_lcd_reg[16];
            o_lcd_on <= i_lcd_reg[31];

            // A request not launched directly refills the slot, even one just popped.
            if (pop_pend) pend_valid <= 1'b0;
            if (req && !take_req) begin
                if (pend_valid && !pop_pend) begin
                    o_overflow <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_word  <= req_word;
                end
            end

            case (state)
                IDLE: begin
                    if (launch) begin
                        o_lcd_rs   <= launch_word[8];
                        o_lcd_data <= launch_word[7:0];
                        cnt        <= AS_LD;
                        state      <= SETUP;
`ifdef LCD_CTRL_INIT_EN
                        if (init_work) init_idx <= init_idx + 3'd1;
`endif
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        o_lcd_en <= 1'b1;
                        cnt      <= PW_LD;
                        state    <= PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        o_lcd_en <= 1'b0;
                        cnt      <= H_LD;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= exec_long ? LONG_LD : EXEC_LD;
                        state <= WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
`ifdef LCD_CTRL_INIT_EN
                INIT: begin
                    if (cnt == '0) state <= IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: a timestamp-based acceptance model predicts each
// EN strobe (word and rise edge); a negedge monitor pops and checks every strobe.
module tb_lcd_ctrl;
    localparam int T_AS    = 2;
    localparam int T_PW    = 3;
    localparam int T_H     = 2;
    localparam int T_EXEC  = 5;
    localparam int T_LONG  = 20;
    localparam int T_PWRON = 10;
`ifdef LCD_CTRL_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] lcd_reg;
    logic        lcd_on, lcd_en, lcd_rs, lcd_rw, busy, overflow;
    logic [7:0]  lcd_data;

    lcd_ctrl #(
        .T_AS_CYC(T_AS), .T_PW_CYC(T_PW), .T_H_CYC(T_H),
        .T_EXEC_CYC(T_EXEC), .T_EXEC_LONG_CYC(T_LONG), .T_PWRON_CYC(T_PWRON)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_lcd_reg(lcd_reg),
        .o_lcd_on(lcd_on), .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
        .o_lcd_data(lcd_data), .o_busy(busy), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rs;
        bit [7:0] data;
        int       rise;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: edge_n counts clock edges since reset release;
    // free_at is the first edge at which the controller can start a new write.
    int       edge_n    = 0;
    int       free_at   = INIT_EN ? T_PWRON + 1 : 0;
    int       init_left = INIT_EN ? 4 : 0;
    bit       pend_v    = 0;
    bit [8:0] pend_w    = 0;
    bit       go_prev   = 0;
    bit       ovf_exp   = 0;
    bit       on_exp    = 0;
    bit [7:0] init_rom [4];

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, edge_n);
        end
    endtask

    function automatic bit model_busy();
        return (edge_n + 1 < free_at) || pend_v || (init_left > 0);
    endfunction

    function automatic void model_launch(input bit [8:0] w);
        exp_t x;
        int   d;
        x.rs   = w[8];
        x.data = w[7:0];
        x.rise = edge_n + T_AS;
        exp_q.push_back(x);
        d = T_AS + T_PW + T_H +
            ((!w[8] && w[7:0] >= 8'd1 && w[7:0] <= 8'd3) ? T_LONG : T_EXEC);
        free_at = edge_n + d + 1;
    endfunction

    function automatic void model_reset();
        edge_n    = 0;
        free_at   = INIT_EN ? T_PWRON + 1 : 0;
        init_left = INIT_EN ? 4 : 0;
        pend_v    = 0;
        go_prev   = 0;
        ovf_exp   = 0;
        on_exp    = 0;
        exp_q.delete();
    endfunction

    initial begin
        bit       req, consumed;
        bit [8:0] w;
        init_rom[0] = 8'h38; init_rom[1] = 8'h0C; init_rom[2] = 8'h01; init_rom[3] = 8'h06;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                edge_n++;
                req      = lcd_reg[16] && !go_prev;
                w        = {lcd_reg[9], lcd_reg[7:0]};
                go_prev  = lcd_reg[16];
                on_exp   = lcd_reg[31];
                consumed = 0;
                if (edge_n >= free_at) begin
                    if (init_left > 0) begin
                        model_launch({1'b0, init_rom[4 - init_left]});
                        init_left--;
                    end else if (pend_v) begin
                        model_launch(pend_w);
                        pend_v = 0;
                    end else if (req) begin
                        model_launch(w);
                        consumed = 1;
                    end
                end
                if (req && !consumed) begin
                    if (pend_v) ovf_exp = 1;
                    else begin
                        pend_v = 1;
                        pend_w = w;
                    end
                end
            end
        end
    end

    // Monitor: status every cycle, full strobe timing whenever EN moves.
    initial begin
        bit       en_prev = 0;
        int       width = 0;
        int       hold_left = 0;
        int       npulse = 0;
        bit       cur_rs;
        bit [7:0] cur_d;
        exp_t     x;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_prev   = 0;
                width     = 0;
                hold_left = 0;
                continue;
            end
            chk("busy", busy, model_busy());
            chk("overflow", overflow, ovf_exp);
            chk("lcd_on", lcd_on, on_exp);
            chk("rw", lcd_rw, 0);
            if (lcd_en && !en_prev) begin
                cur_rs = lcd_rs;
                cur_d  = lcd_data;
                width  = 1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    chk("pulse_rs", lcd_rs, x.rs);
                    chk("pulse_data", lcd_data, x.data);
                    chk("pulse_rise_edge", edge_n, x.rise);
                end
            end else if (lcd_en && en_prev) begin
                width++;
                chk("pulse_stable", {lcd_rs, lcd_data}, {cur_rs, cur_d});
            end else if (!lcd_en && en_prev) begin
                chk("pulse_width", width, T_PW);
                hold_left = T_H;
                npulse++;
                $display("pulse %0d: rs=%0d data=0x%02h width=%0d at edge %0d",
                         npulse, cur_rs, cur_d, width, edge_n);
            end
            if (hold_left > 0) begin
                chk("hold_stable", {lcd_rs, lcd_data}, {cur_rs, cur_d});
                hold_left--;
            end
            en_prev = lcd_en;
        end
    end

    task automatic wr(input bit on, input bit rs, input bit [7:0] d, input int hold);
        logic [31:0] w;
        w      = $urandom();
        w[31]  = on;
        w[16]  = 1'b1;
        w[9]   = rs;
        w[7:0] = d;
        @(negedge clk);
        lcd_reg = w;
        repeat (hold) @(negedge clk);
        lcd_reg[16] = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || model_busy()) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", (n < 4000) ? 1 : 0, 1);
        chk("drain_en_low", lcd_en, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_en", lcd_en, 0);
        chk("rst_busy", busy, INIT_EN);
        chk("rst_overflow", overflow, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_data", lcd_data, 0);
        chk("rst_on", lcd_on, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       n;
        bit [7:0] d;
        rst_n   = 1'b0;
        lcd_reg = 32'h0;
        #1;
        chk("por_en", lcd_en, 0);
        chk("por_busy", busy, INIT_EN);
        chk("por_overflow", overflow, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Basic write, clear (long wait), set-DDRAM (normal wait)
        wr(1'b1, 1'b1, 8'h41, 1);
        drain();
        wr(1'b1, 1'b0, 8'h01, 1);
        drain();
        wr(1'b0, 1'b0, 8'h80, 1);
        drain();

        // GO level held: one strobe only
        wr(1'b1, 1'b1, 8'h55, 50);
        drain();

        // Three edges during one transfer: second pends, third overflows
        wr(1'b0, 1'b1, 8'h31, 1);
        wr(1'b0, 1'b1, 8'h32, 1);
        wr(1'b0, 1'b1, 8'h33, 1);
        idle(2);
        chk("overflow_sticky", overflow, 1);
        drain();

        // Reset while EN is high
        wr(1'b1, 1'b1, 8'h66, 1);
        n = 0;
        while (!lcd_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_en_high", lcd_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_en", lcd_en, 0);
        chk("midrst_busy", busy, INIT_EN);
        chk("midrst_overflow", overflow, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wr(1'b1, 1'b1, 8'h77, 1);
        drain();

        // Randomised traffic, biased toward the long-wait commands
        for (int i = 0; i < 40; i++) begin
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom());
            wr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d, $urandom_range(1, 4));
            idle($urandom_range(0, 25));
        end
        drain();

        do_reset();
        wr(1'b1, 1'b0, 8'h02, 2);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
